// File: rtl/booth_pp_accumulator.sv
// +--------------------------------------------------------------------------+
// | booth_pp_accumulator: sequential radix-4 Booth partial-product summer    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module booth_pp_accumulator #(
  parameter int PP_W  = 17,
  parameter int ROWS  = 8,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pp_valid,
  output logic             pp_ready,
  input  logic [PP_W-1:0]  pp,
  input  logic             pp_neg,
  output logic             busy,
  output logic             prod_valid,
  input  logic             prod_ready,
  output logic [OUT_W-1:0] product
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             busy_q, busy_d;
  logic             prod_valid_q, prod_valid_d;

  logic             beat;
  logic [ROW_W:0]   shamt;
  logic [OUT_W-1:0] pp_ext;
  logic [OUT_W-1:0] neg_ext;
  logic [OUT_W-1:0] term;
  logic [OUT_W-1:0] base;

  assign pp_ready = (state_q == ACCUM);
  assign beat     = pp_valid && pp_ready;

  // Row k carries weight 4^k, so both the row and its +1 land at bit 2k.
  assign shamt   = {row_q, 1'b0};
  assign pp_ext  = {{(OUT_W-PP_W){pp[PP_W-1]}}, pp};
  assign neg_ext = {{(OUT_W-1){1'b0}}, pp_neg};
  assign term    = (pp_ext << shamt) + (neg_ext << shamt);

  // Clearing on row 0 instead of on start keeps the previous product visible
  // in IDLE until the next operation actually delivers data.
  assign base = (row_q == '0) ? '0 : acc_q;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    row_d        = row_q;
    busy_d       = busy_q;
    prod_valid_d = prod_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          row_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = base + term;
          if (row_q == LAST_ROW) begin
            state_d      = DONE;
            row_d        = '0;
            prod_valid_d = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      DONE: begin
        if (prod_ready) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          prod_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        row_d        = '0;
        busy_d       = 1'b0;
        prod_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      prod_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      row_q        <= row_d;
      busy_q       <= busy_d;
      prod_valid_q <= prod_valid_d;
    end
  end

  assign busy       = busy_q;
  assign prod_valid = prod_valid_q;
  assign product    = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench for booth_pp_accumulator: directed rows plus Booth-model pairs.
`timescale 1ns/1ps
`default_nettype none

module tb_booth_pp_accumulator;
  localparam int PP_W  = 17;
  localparam int ROWS  = 8;
  localparam int OUT_W = 32;
  localparam int WAIT_MAX = 50;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             pp_valid;
  logic             pp_ready;
  logic [PP_W-1:0]  pp;
  logic             pp_neg;
  logic             busy;
  logic             prod_valid;
  logic             prod_ready;
  logic [OUT_W-1:0] product;

  booth_pp_accumulator #(.PP_W(PP_W), .ROWS(ROWS), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pp_valid   (pp_valid),
    .pp_ready   (pp_ready),
    .pp         (pp),
    .pp_neg     (pp_neg),
    .busy       (busy),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .product    (product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0]     exp_q[$];
  logic [PP_W-1:0] row_pp[ROWS];
  logic            row_neg[ROWS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic finish_bench();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: got no event within %0d cycles, want event", name, WAIT_MAX);
    finish_bench();
  endtask

  // Monitor: every product handshake is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (prod_valid === 1'b1 && prod_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_product: got 0x%08h, want no product", product);
        end else begin
          chk("product", product, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    n_checks++;
    $display("FAIL watchdog: got simulation still running, want completion");
    finish_bench();
  end

  task automatic clear_rows();
    for (int k = 0; k < ROWS; k++) begin
      row_pp[k]  = '0;
      row_neg[k] = 1'b0;
    end
  endtask

  // Radix-4 Booth row generator: digit from bits (2k+1, 2k, 2k-1) of b.
  task automatic booth_rows(input logic signed [15:0] a, input logic [15:0] b);
    logic [16:0] bx;
    logic [2:0]  t;
    bx = {b, 1'b0};
    for (int k = 0; k < ROWS; k++) begin
      t = bx[2*k +: 3];
      case (t)
        3'b001, 3'b010: begin row_pp[k] = {a[15], a};     row_neg[k] = 1'b0; end
        3'b011:         begin row_pp[k] = {a, 1'b0};      row_neg[k] = 1'b0; end
        3'b100:         begin row_pp[k] = ~{a, 1'b0};     row_neg[k] = 1'b1; end
        3'b101, 3'b110: begin row_pp[k] = ~{a[15], a};    row_neg[k] = 1'b1; end
        default:        begin row_pp[k] = '0;             row_neg[k] = 1'b0; end
      endcase
    end
  endtask

  task automatic run_op(input logic [31:0] exp, input int pp_stall, input bit rand_stall,
                        input int prod_hold, input int start_after, input int abort_after,
                        input bit check_lat);
    int s;
    int w;
    int st;
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    if (abort_after < 0) exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < ROWS; k++) begin
      st = rand_stall ? int'($urandom_range(0, 2)) : pp_stall;
      if (k > 0) repeat (st) begin @(posedge clk); #1; end
      pp_valid = 1'b1;
      pp       = row_pp[k];
      pp_neg   = row_neg[k];
      if (start_after >= 0 && k == start_after + 1) start = 1'b1;
      w = 0;
      forever begin
        @(negedge clk);
        if (pp_ready === 1'b1) break;
        w++;
        if (w > WAIT_MAX) timeout("pp_ready_wait");
      end
      @(posedge clk); #1;
      pp_valid = 1'b0;
      pp       = PP_W'($urandom);
      pp_neg   = 1'($urandom);
      start    = 1'b0;
      if (k == abort_after) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_prod_valid", 32'(prod_valid), 32'd0);
        chk("abort_product", product, 32'd0);
        chk("abort_pp_ready", 32'(pp_ready), 32'd0);
        return;
      end
    end
    w = 0;
    forever begin
      @(negedge clk);
      if (prod_valid === 1'b1) break;
      w++;
      if (w > WAIT_MAX) timeout("prod_valid_wait");
    end
    if (check_lat) chk("latency", 32'(cyc - s), 32'd9);
    chk("done_busy", 32'(busy), 32'd1);
    repeat (prod_hold) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", 32'(prod_valid), 32'd1);
      chk("hold_product", product, exp);
    end
    @(posedge clk); #1;
    prod_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    prod_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop", 32'(prod_valid), 32'd0);
    chk("idle_product_kept", product, exp);
  endtask

  initial begin
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [31:0] p;
    rst = 1'b1; start = 1'b0; pp_valid = 1'b0; pp = '0; pp_neg = 1'b0; prod_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_prod_valid", 32'(prod_valid), 32'd0);
    chk("reset_product", product, 32'd0);
    chk("reset_pp_ready", 32'(pp_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // pp_valid in IDLE must not be accepted
    pp_valid = 1'b1; pp = 17'h00005;
    repeat (2) begin
      @(negedge clk);
      chk("idle_pp_ready", 32'(pp_ready), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    pp_valid = 1'b0;

    // A=3, B=5
    clear_rows(); row_pp[0] = 17'h00003; row_pp[1] = 17'h00003;
    run_op(32'h0000000F, 0, 0, 0, -1, -1, 1);
    // A=3, B=-1
    clear_rows(); row_pp[0] = 17'h1FFFC; row_neg[0] = 1'b1;
    run_op(32'hFFFFFFFD, 0, 0, 0, -1, -1, 1);
    // all-ones row with neg cancels to zero
    clear_rows(); row_pp[3] = 17'h1FFFF; row_neg[3] = 1'b1;
    run_op(32'h00000000, 0, 0, 0, -1, -1, 1);
    // stalls on both handshakes
    clear_rows(); row_pp[0] = 17'h00003; row_pp[1] = 17'h00003;
    run_op(32'h0000000F, 3, 0, 5, -1, -1, 0);
    // start pulsed mid-accumulation is ignored
    run_op(32'h0000000F, 0, 0, 0, 2, -1, 1);
    // reset after row 4, then a fresh operation
    clear_rows(); row_pp[0] = 17'h1FFFC; row_neg[0] = 1'b1; row_pp[5] = 17'h00007;
    run_op(32'h0, 0, 0, 0, -1, 4, 0);
    clear_rows(); row_pp[0] = 17'h1FFFC; row_neg[0] = 1'b1;
    run_op(32'hFFFFFFFD, 0, 0, 0, -1, -1, 1);

    for (int i = 0; i < 1000; i++) begin
      case (i)
        0: begin a = -16'sd32768; b = -16'sd32768; end
        1: begin a = 16'sd32767;  b = -16'sd32768; end
        2: begin a = -16'sd1;     b = -16'sd1;     end
        3: begin a = 16'sd0;      b = 16'sd12345;  end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      p = a * b;
      booth_rows(a, b);
      run_op(p, 0, 1, int'($urandom_range(0, 3)), -1, -1, 0);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    finish_bench();
  end

endmodule

`default_nettype wire
